// File: rtl/flash_spi_responder.sv
// SPI NOR flash responder: decodes READ/PP/SE/BE/RDSR/WREN/WRDI from an
// oversampled mode-0 SPI bus and drives a simple byte-wide backing memory.
//
// Memory port handshake: mem_rd and mem_wr are single-cycle strobes that
// are never asserted in the same cycle. mem_addr and mem_wdata are valid
// while their strobe is high. mem_rdata must be valid during the cycle
// immediately after mem_rd, and it is captured at the end of that cycle.
module flash_spi_responder #(
    parameter int ADDR_W      = 16,
    parameter int SECTOR_W    = 12,
    parameter int PROG_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_c,
    input  logic              spi_d,
    input  logic              spi_csn,
    input  logic              spi_wpn,
    output logic              spi_q,
    output logic              spi_q_oe,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    output logic [3:0]        dbg_state
);

    localparam int CNT_W = $clog2(PROG_CYCLES + 1);
    localparam logic [ADDR_W:0] SECT_BYTES = ((ADDR_W+1)'(1)) << SECTOR_W;
    localparam logic [ADDR_W:0] ALL_BYTES  = ((ADDR_W+1)'(1)) << ADDR_W;

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, PROG, READ, STATUS, IGNORE, ERASE, BUSY
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_READ, OP_PP, OP_SE, OP_BE, OP_WREN, OP_WRDI
    } op_t;

    // synchronizer stages plus one history flop for edge detection
    logic c_m, c_s, c_p;
    logic d_m, d_s;
    logic csn_m, csn_s, csn_p;
    logic wpn_m, wpn_s;

    state_t            state;
    op_t               op;
    logic              wel, wip, job_erase;
    logic [CNT_W-1:0]  busy_cnt;
    logic [ADDR_W-1:0] erase_ptr;
    logic [ADDR_W:0]   erase_left;
    logic [5:0]        bit_cnt;      // saturates at 40
    logic [2:0]        bit_idx;      // bit position within the current byte
    logic [2:0]        out_cnt;      // bits already shifted out of this byte
    logic [6:0]        sr_in;
    logic [ADDR_W-1:0] addr;         // upper wire address bits fall off the top
    logic [7:0]        sr_out;
    logic [7:0]        rd_buf;       // next byte to send on spi_q
    logic [ADDR_W-1:0] rd_addr;      // prefetch address
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        pdata;
    logic              wr_pend;      // outstanding read belongs to a program merge
    logic              mem_rd_d;

    logic              c_rise, c_fall, csn_rise, csn_fall, active;
    logic [7:0]        rx_byte, status_byte, out_byte;
    logic [ADDR_W-1:0] addr_next;

    assign c_rise      = c_s & ~c_p;
    assign c_fall      = ~c_s & c_p;
    assign csn_rise    = csn_s & ~csn_p;
    assign csn_fall    = ~csn_s & csn_p;
    assign active      = (state == CMD) || (state == ADDR) || (state == PROG) ||
                         (state == READ) || (state == STATUS) || (state == IGNORE);
    assign rx_byte     = {sr_in, d_s};
    assign addr_next   = {addr[ADDR_W-2:0], d_s};
    assign status_byte = {6'b0, wel, wip};
    assign out_byte    = (state == STATUS) ? status_byte : rd_buf;
    assign busy        = wip;
    assign dbg_state   = state;

    // bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_m   <= 1'b0; c_s   <= 1'b0; c_p   <= 1'b0;
            d_m   <= 1'b0; d_s   <= 1'b0;
            csn_m <= 1'b1; csn_s <= 1'b1; csn_p <= 1'b1;
            wpn_m <= 1'b1; wpn_s <= 1'b1;
        end else begin
            c_m   <= spi_c;   c_s   <= c_m;   c_p   <= c_s;
            d_m   <= spi_d;   d_s   <= d_m;
            csn_m <= spi_csn; csn_s <= csn_m; csn_p <= csn_s;
            wpn_m <= spi_wpn; wpn_s <= wpn_m;
        end
    end

    // protocol FSM, background program/erase engine and memory port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op         <= OP_NONE;
            wel        <= 1'b0;
            wip        <= 1'b0;
            job_erase  <= 1'b0;
            busy_cnt   <= '0;
            erase_ptr  <= '0;
            erase_left <= '0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            out_cnt    <= '0;
            sr_in      <= '0;
            addr       <= '0;
            sr_out     <= '0;
            rd_buf     <= '0;
            rd_addr    <= '0;
            prog_addr  <= '0;
            pdata      <= '0;
            wr_pend    <= 1'b0;
            mem_rd_d   <= 1'b0;
            spi_q      <= 1'b0;
            spi_q_oe   <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_rd_d <= mem_rd;

            // read data return: either a read-stream byte or a program merge
            if (mem_rd_d) begin
                if (wr_pend) begin
                    mem_wr    <= 1'b1;
                    mem_wdata <= pdata & mem_rdata;
                    wr_pend   <= 1'b0;
                end else begin
                    rd_buf <= mem_rdata;
                end
            end

            // background job runs regardless of chip-select activity
            if (wip) begin
                if (job_erase) begin
                    if (erase_left != '0) begin
                        mem_wr     <= 1'b1;
                        mem_addr   <= erase_ptr;
                        mem_wdata  <= 8'hFF;
                        erase_ptr  <= erase_ptr + 1'b1;
                        erase_left <= erase_left - 1'b1;
                    end else begin
                        wip <= 1'b0;
                    end
                end else if (busy_cnt == '0) begin
                    wip <= 1'b0;
                end else begin
                    busy_cnt <= busy_cnt - 1'b1;
                end
            end else if (state == ERASE || state == BUSY) begin
                state <= IDLE;
            end

            if (csn_rise) begin
                if (active) begin
                    spi_q_oe <= 1'b0;
                    spi_q    <= 1'b0;
                    state    <= wip ? (job_erase ? ERASE : BUSY) : IDLE;
                    case (op)
                        OP_WREN: if (bit_cnt == 6'd8) wel <= 1'b1;
                        OP_WRDI: if (bit_cnt == 6'd8) wel <= 1'b0;
                        OP_PP: begin
                            if (bit_cnt == 6'd40 && bit_idx == 3'd0) begin
                                wel       <= 1'b0;
                                wip       <= 1'b1;
                                job_erase <= 1'b0;
                                busy_cnt  <= CNT_W'(PROG_CYCLES - 1);
                                state     <= BUSY;
                            end
                        end
                        OP_SE: begin
                            if (bit_cnt == 6'd32) begin
                                wel        <= 1'b0;
                                wip        <= 1'b1;
                                job_erase  <= 1'b1;
                                erase_ptr  <= {addr[ADDR_W-1:SECTOR_W], {SECTOR_W{1'b0}}};
                                erase_left <= SECT_BYTES;
                                state      <= ERASE;
                            end
                        end
                        OP_BE: begin
                            if (bit_cnt == 6'd8) begin
                                wel        <= 1'b0;
                                wip        <= 1'b1;
                                job_erase  <= 1'b1;
                                erase_ptr  <= '0;
                                erase_left <= ALL_BYTES;
                                state      <= ERASE;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (csn_fall) begin
                state   <= CMD;
                op      <= OP_NONE;
                bit_cnt <= '0;
                bit_idx <= '0;
                out_cnt <= '0;
            end else if (!csn_s && active) begin
                if (c_rise) begin
                    sr_in   <= rx_byte[6:0];
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_cnt != 6'd40) bit_cnt <= bit_cnt + 1'b1;
                    case (state)
                        CMD: begin
                            if (bit_idx == 3'd7) begin
                                state <= IGNORE;
                                if (wip) begin
                                    if (rx_byte == 8'h05) begin
                                        state    <= STATUS;
                                        spi_q_oe <= 1'b1;
                                        out_cnt  <= '0;
                                    end
                                end else begin
                                    case (rx_byte)
                                        8'h03: begin op <= OP_READ; state <= ADDR; end
                                        8'h02: if (wel && wpn_s) begin op <= OP_PP; state <= ADDR; end
                                        8'hD8: if (wel && wpn_s) begin op <= OP_SE; state <= ADDR; end
                                        8'hC7: if (wel && wpn_s) op <= OP_BE;
                                        8'h06: op <= OP_WREN;
                                        8'h04: op <= OP_WRDI;
                                        8'h05: begin
                                            state    <= STATUS;
                                            spi_q_oe <= 1'b1;
                                            out_cnt  <= '0;
                                        end
                                        default: ;
                                    endcase
                                end
                            end
                        end
                        ADDR: begin
                            addr <= addr_next;
                            if (bit_cnt == 6'd31) begin
                                case (op)
                                    OP_READ: begin
                                        state    <= READ;
                                        mem_rd   <= 1'b1;
                                        mem_addr <= addr_next;
                                        rd_addr  <= addr_next + 1'b1;
                                        out_cnt  <= '0;
                                        spi_q_oe <= 1'b1;
                                    end
                                    OP_PP: begin
                                        state     <= PROG;
                                        prog_addr <= addr_next;
                                    end
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                        PROG: begin
                            if (bit_idx == 3'd7) begin
                                mem_rd    <= 1'b1;
                                mem_addr  <= prog_addr;
                                pdata     <= rx_byte;
                                wr_pend   <= 1'b1;
                                prog_addr <= {prog_addr[ADDR_W-1:8], prog_addr[7:0] + 8'd1};
                            end
                        end
                        default: ;
                    endcase
                end else if (c_fall && (state == READ || state == STATUS)) begin
                    out_cnt <= out_cnt + 1'b1;
                    if (out_cnt == 3'd0) begin
                        spi_q  <= out_byte[7];
                        sr_out <= {out_byte[6:0], 1'b0};
                        if (state == READ) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= rd_addr;
                            rd_addr  <= rd_addr + 1'b1;
                        end
                    end else begin
                        spi_q  <= sr_out[7];
                        sr_out <= {sr_out[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_flash_spi_responder.sv
// Bench for flash_spi_responder: byte-wide memory model, bit-banged SPI
// master, table of read vectors and hand-written program/erase sequences.
module tb_flash_spi_responder;

    localparam int ADDR_W      = 16;
    localparam int SECTOR_W    = 12;
    localparam int PROG_CYCLES = 32;
    localparam int HALF        = 8;

    logic              clk, rst;
    logic              spi_c, spi_d, spi_csn, spi_wpn;
    logic              spi_q, spi_q_oe, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd, mem_wr;
    logic [7:0]        mem_rdata, mem_wdata;
    logic [3:0]        dbg_state;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int rd_count = 0;
    int conflict_count = 0;
    int busy_cycles = 0;

    logic [7:0] mem [0:65535];

    flash_spi_responder #(
        .ADDR_W(ADDR_W), .SECTOR_W(SECTOR_W), .PROG_CYCLES(PROG_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .spi_c(spi_c), .spi_d(spi_d), .spi_csn(spi_csn), .spi_wpn(spi_wpn),
        .spi_q(spi_q), .spi_q_oe(spi_q_oe), .busy(busy),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // backing memory model: read data appears the cycle after mem_rd
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem[mem_addr];
            rd_count++;
        end
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_count++;
        end
        if (mem_rd && mem_wr) conflict_count++;
        if (busy) busy_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_csn = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        spi_csn = 1'b1;
        wait_clk(2*HALF);
    endtask

    // mode 0: master samples spi_q just before raising spi_c
    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_d = tx[7-i];
            wait_clk(HALF);
            rx = {rx[6:0], spi_q};
            spi_c = 1'b1;
            wait_clk(HALF);
            spi_c = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        xfer_bits(tx, 8, rx);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [7:0] junk;
        xfer(a[23:16], junk);
        xfer(a[15:8], junk);
        xfer(a[7:0], junk);
    endtask

    task automatic cmd_only(input logic [7:0] opc);
        logic [7:0] junk;
        cs_begin();
        xfer(opc, junk);
        cs_end();
    endtask

    task automatic rdsr(output logic [7:0] s0, output logic [7:0] s1);
        logic [7:0] junk;
        cs_begin();
        xfer(8'h05, junk);
        xfer(8'h00, s0);
        xfer(8'h00, s1);
        cs_end();
    endtask

    task automatic wait_not_busy(input int limit, input string name);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
    } rd_vec_t;

    rd_vec_t rv [4];

    initial begin
        logic [7:0] r0, r1, junk;
        int wc, rc;

        rv[0] = '{24'h000100, 8'hA5, 8'h3C};
        rv[1] = '{24'h00FFFF, 8'h77, 8'h11};
        rv[2] = '{24'h12ABCD, 8'h5A, 8'hC3};
        rv[3] = '{24'h000000, 8'h11, 8'h22};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'hA5; mem[16'h0101] = 8'h3C;
        mem[16'hFFFF] = 8'h77; mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22;
        mem[16'hABCD] = 8'h5A; mem[16'hABCE] = 8'hC3;
        mem[16'h0FFF] = 8'h12; mem[16'h2000] = 8'h34; mem[16'h8000] = 8'h5C;

        // reset
        rst = 1'b1; spi_c = 1'b0; spi_d = 1'b0; spi_csn = 1'b1; spi_wpn = 1'b1;
        wait_clk(3);
        check("rst_spi_q", spi_q, 1'b0);
        check("rst_oe", spi_q_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_state", dbg_state, 4'd0);
        rst = 1'b0;
        wait_clk(4);

        // read vectors
        for (int i = 0; i < 4; i++) begin
            cs_begin();
            xfer(8'h03, junk);
            send_addr(rv[i].addr);
            xfer(8'h00, r0);
            check($sformatf("read%0d_byte0", i), r0, rv[i].exp0);
            xfer(8'h00, r1);
            check($sformatf("read%0d_byte1", i), r1, rv[i].exp1);
            check($sformatf("read%0d_oe_on", i), spi_q_oe, 1'b1);
            cs_end();
            check($sformatf("read%0d_oe_off", i), spi_q_oe, 1'b0);
        end

        // WREN cut short after 7 bits leaves WEL clear
        cs_begin();
        xfer_bits(8'h06, 7, junk);
        cs_end();
        rdsr(r0, r1);
        check("wren7_sr0", r0, 8'h00);
        check("wren7_sr1", r1, 8'h00);

        // page program without WREN is ignored
        wc = wr_count;
        cs_begin();
        xfer(8'h02, junk); send_addr(24'h000010); xfer(8'hAA, junk); xfer(8'hBB, junk);
        cs_end();
        wait_clk(4*HALF);
        check("pp_nowel_writes", wr_count - wc, 0);
        check("pp_nowel_busy", busy, 1'b0);
        rdsr(r0, r1);
        check("pp_nowel_sr", r0, 8'h00);

        // WREN sets WEL; program with write protect low is ignored
        cmd_only(8'h06);
        rdsr(r0, r1);
        check("wren_sr", r0, 8'h02);
        spi_wpn = 1'b0;
        wait_clk(4);
        wc = wr_count;
        cs_begin();
        xfer(8'h02, junk); send_addr(24'h000010); xfer(8'hAA, junk); xfer(8'hBB, junk);
        cs_end();
        wait_clk(4*HALF);
        check("pp_wp_writes", wr_count - wc, 0);
        check("pp_wp_busy", busy, 1'b0);
        spi_wpn = 1'b1;
        wait_clk(4);
        cmd_only(8'h04);
        rdsr(r0, r1);
        check("wrdi_sr", r0, 8'h00);

        // page program with wrap inside the page
        mem[16'h01FE] = 8'hFF; mem[16'h01FF] = 8'hFF; mem[16'h0100] = 8'hFF;
        cmd_only(8'h06);
        wc = wr_count;
        busy_cycles = 0;
        cs_begin();
        xfer(8'h02, junk); send_addr(24'h0001FE);
        xfer(8'hF0, junk); xfer(8'h0F, junk); xfer(8'h3C, junk);
        cs_end();
        wait_not_busy(200, "pp_busy_timeout");
        check("pp_mem_01fe", mem[16'h01FE], 8'hF0);
        check("pp_mem_01ff", mem[16'h01FF], 8'h0F);
        check("pp_mem_0100", mem[16'h0100], 8'h3C);
        check("pp_writes", wr_count - wc, 3);
        check("pp_busy_cycles", busy_cycles, PROG_CYCLES);
        rdsr(r0, r1);
        check("pp_after_sr", r0, 8'h00);

        // sector erase
        mem[16'h1234] = 8'h99;
        cmd_only(8'h06);
        wc = wr_count;
        cs_begin();
        xfer(8'hD8, junk); send_addr(24'h001234);
        cs_end();
        check("se_busy", busy, 1'b1);
        rdsr(r0, r1);
        check("se_sr0", r0, 8'h01);
        check("se_sr1", r1, 8'h01);
        rc = rd_count;
        cs_begin();
        xfer(8'h03, junk); send_addr(24'h000100); xfer(8'h00, junk);
        cs_end();
        check("se_read_blocked", rd_count - rc, 0);
        wait_not_busy(6000, "se_busy_timeout");
        check("se_mem_1000", mem[16'h1000], 8'hFF);
        check("se_mem_1234", mem[16'h1234], 8'hFF);
        check("se_mem_1fff", mem[16'h1FFF], 8'hFF);
        check("se_mem_0fff", mem[16'h0FFF], 8'h12);
        check("se_mem_2000", mem[16'h2000], 8'h34);
        check("se_writes", wr_count - wc, 4096);
        rdsr(r0, r1);
        check("se_after_sr", r0, 8'h00);

        // bulk erase abandoned by reset
        cmd_only(8'h06);
        cs_begin();
        xfer(8'hC7, junk);
        cs_end();
        wait_clk(50);
        check("be_busy", busy, 1'b1);
        check("be_mem_0000", mem[16'h0000], 8'hFF);
        rst = 1'b1;
        @(negedge clk);
        check("be_rst_busy", busy, 1'b0);
        check("be_rst_mem_wr", mem_wr, 1'b0);
        rst = 1'b0;
        wc = wr_count;
        wait_clk(50);
        check("be_rst_writes", wr_count - wc, 0);
        check("be_mem_8000", mem[16'h8000], 8'h5C);
        rdsr(r0, r1);
        check("be_rst_sr", r0, 8'h00);

        check("port_conflict", conflict_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
